// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: control-word bit layout,
// status flag indices, sequencer state encoding and divide step count.
package alu_seq_pkg;

    // ALU control word bit indices (12-bit cntl)
    localparam int ALU_ADD       = 0;
    localparam int ALU_SUB       = 1;
    localparam int ALU_AND       = 2;
    localparam int ALU_OR        = 3;
    localparam int ALU_XOR       = 4;
    localparam int ALU_SHL       = 5;
    localparam int ALU_SHR       = 6;
    localparam int ALU_DIV       = 7;
    localparam int ALU_USE_CARRY = 8;
    localparam int ALU_NO_WR     = 9;

    // Plain subtract with no carry-in, used for every divide step
    localparam logic [11:0] ALU_OP_SUB = 12'h002;

    // Status flag indices, bit order {CF,PF,ZF,SF,OF}
    localparam int STAT_CF = 4;
    localparam int STAT_PF = 3;
    localparam int STAT_ZF = 2;
    localparam int STAT_SF = 1;
    localparam int STAT_OF = 0;

    // Number of quotient bits produced by the restoring divider
    localparam int ALUSEQ_DIV_STEPS = 32;

    typedef enum logic [1:0] {
        ALUSEQ_IDLE = 2'd0,
        ALUSEQ_EXEC = 2'd1,
        ALUSEQ_DIV  = 2'd2,
        ALUSEQ_RESP = 2'd3
    } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_div_step.sv
// One restoring-divide step. The subtraction itself is done by the shared
// ALU; this block forms the shifted partial remainder fed to the ALU and
// decides from the ALU borrow whether the subtraction is kept.
module alu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             quo_msb,
    input  logic [WIDTH:0]   sub_res,
    output logic [WIDTH-1:0] shifted,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic top;

    // Shift in the next dividend bit; a set top bit means the true partial
    // remainder exceeds WIDTH bits, so the subtract must be taken regardless
    // of the borrow.
    always_comb begin
        shifted  = {rem_in[WIDTH-2:0], quo_msb};
        top      = rem_in[WIDTH-1];
        q_bit    = top | ~sub_res[WIDTH];
        rem_next = q_bit ? sub_res[WIDTH-1:0] : shifted;
    end

endmodule

// File: rtl/alu_seq.sv
// ALU sequencer: accepts one operation at a time, drives the external ALU,
// runs DIV as a 32-step restoring divide through the ALU subtractor, and
// owns the architectural flags register, committed on response handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int          WIDTH         = 32,
    parameter logic [4:0]  FLAGS_RST     = 5'b00000,
    parameter logic [31:0] DIV_FAULT_VAL = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [11:0]      req_cntl,
    input  logic [WIDTH-1:0] req_opnd0,
    input  logic [WIDTH-1:0] req_opnd1,
    output logic [11:0]      alu_cntl,
    output logic [4:0]       alu_status_in,
    output logic [WIDTH-1:0] alu_opnd0,
    output logic [WIDTH-1:0] alu_opnd1,
    input  logic [4:0]       alu_status_out,
    input  logic [WIDTH:0]   alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_wr,
    output logic             rsp_fault,
    output logic [4:0]       flags
);

    alu_seq_state_t   state_q, state_d;
    logic [11:0]      op_cntl_q, op_cntl_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_wr_q, rsp_wr_d;
    logic             rsp_fault_q, rsp_fault_d;
    logic [4:0]       flags_q, flags_d;
    logic [4:0]       next_flags_q, next_flags_d;

    logic [WIDTH-1:0] div_shifted;
    logic [WIDTH-1:0] div_rem_next;
    logic             div_q_bit;

    alu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (rem_q),
        .quo_msb  (quo_q[WIDTH-1]),
        .sub_res  (alu_result),
        .shifted  (div_shifted),
        .rem_next (div_rem_next),
        .q_bit    (div_q_bit)
    );

    // ALU drive: operands only in EXEC and during active divide steps
    always_comb begin
        alu_cntl  = '0;
        alu_opnd0 = '0;
        alu_opnd1 = '0;
        case (state_q)
            ALUSEQ_EXEC: begin
                alu_cntl  = op_cntl_q;
                alu_opnd0 = op_a_q;
                alu_opnd1 = op_b_q;
            end
            ALUSEQ_DIV: begin
                if (cnt_q != 6'd0) begin
                    alu_cntl  = ALU_OP_SUB;
                    alu_opnd0 = div_shifted;
                    alu_opnd1 = op_b_q;
                end
            end
            default: ;
        endcase
    end

    // Next-state, operand latch, divide datapath and response capture
    always_comb begin
        state_d      = state_q;
        op_cntl_d    = op_cntl_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_fault_d  = rsp_fault_q;
        flags_d      = flags_q;
        next_flags_d = next_flags_q;
        case (state_q)
            ALUSEQ_IDLE: begin
                if (req_valid) begin
                    op_cntl_d = req_cntl;
                    op_a_d    = req_opnd0;
                    op_b_d    = req_opnd1;
                    if (req_cntl[ALU_DIV]) begin
                        if (req_opnd1 == '0) begin
                            rsp_result_d = DIV_FAULT_VAL;
                            rsp_wr_d     = 1'b0;
                            rsp_fault_d  = 1'b1;
                            next_flags_d = flags_q;
                            state_d      = ALUSEQ_RESP;
                        end else begin
                            rem_d   = '0;
                            quo_d   = req_opnd0;
                            cnt_d   = 6'(ALUSEQ_DIV_STEPS);
                            state_d = ALUSEQ_DIV;
                        end
                    end else begin
                        state_d = ALUSEQ_EXEC;
                    end
                end
            end
            ALUSEQ_EXEC: begin
                rsp_result_d = alu_result[WIDTH-1:0];
                rsp_wr_d     = ~op_cntl_q[ALU_NO_WR];
                rsp_fault_d  = 1'b0;
                next_flags_d = alu_status_out;
                state_d      = ALUSEQ_RESP;
            end
            ALUSEQ_DIV: begin
                // Counter at zero: all quotient bits done, one cycle to publish
                if (cnt_q != 6'd0) begin
                    rem_d = div_rem_next;
                    quo_d = {quo_q[WIDTH-2:0], div_q_bit};
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    rsp_result_d = quo_q;
                    rsp_wr_d     = ~op_cntl_q[ALU_NO_WR];
                    rsp_fault_d  = 1'b0;
                    next_flags_d = flags_q;
                    state_d      = ALUSEQ_RESP;
                end
            end
            ALUSEQ_RESP: begin
                if (rsp_ready) begin
                    if (!rsp_fault_q) begin
                        flags_d = next_flags_q;
                    end
                    state_d = ALUSEQ_IDLE;
                end
            end
            default: state_d = ALUSEQ_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ALUSEQ_IDLE;
            op_cntl_q    <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            rsp_result_q <= '0;
            rsp_wr_q     <= 1'b0;
            rsp_fault_q  <= 1'b0;
            flags_q      <= FLAGS_RST;
            next_flags_q <= FLAGS_RST;
        end else begin
            state_q      <= state_d;
            op_cntl_q    <= op_cntl_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            cnt_q        <= cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_fault_q  <= rsp_fault_d;
            flags_q      <= flags_d;
            next_flags_q <= next_flags_d;
        end
    end

    // Ready is held low for the whole time reset is asserted
    assign req_ready     = rst_n && (state_q == ALUSEQ_IDLE);
    assign rsp_valid     = (state_q == ALUSEQ_RESP);
    assign rsp_result    = rsp_result_q;
    assign rsp_wr        = rsp_wr_q;
    assign rsp_fault     = rsp_fault_q;
    assign flags         = flags_q;
    assign alu_status_in = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural ALU stand-in closes the loop, a table of
// directed operations with hand-computed results/latency/flags is applied,
// then a stalled-response sequence and a reset-mid-divide sequence.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_cntl;
    logic [31:0] req_opnd0, req_opnd1;
    logic [11:0] alu_cntl;
    logic [4:0]  alu_status_in;
    logic [31:0] alu_opnd0, alu_opnd1;
    logic [4:0]  alu_status_out;
    logic [32:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_wr;
    logic        rsp_fault;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cntl       (req_cntl),
        .req_opnd0      (req_opnd0),
        .req_opnd1      (req_opnd1),
        .alu_cntl       (alu_cntl),
        .alu_status_in  (alu_status_in),
        .alu_opnd0      (alu_opnd0),
        .alu_opnd1      (alu_opnd1),
        .alu_status_out (alu_status_out),
        .alu_result     (alu_result),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_wr         (rsp_wr),
        .rsp_fault      (rsp_fault),
        .flags          (flags)
    );

    // Behavioural stand-in for the external combinational ALU
    logic [32:0] m_r;
    logic        m_of;
    logic        m_cin;
    always_comb begin
        m_r   = '0;
        m_of  = 1'b0;
        m_cin = alu_cntl[ALU_USE_CARRY] & alu_status_in[STAT_CF];
        if (alu_cntl[ALU_ADD]) begin
            m_r  = {1'b0, alu_opnd0} + {1'b0, alu_opnd1} + {32'b0, m_cin};
            m_of = (alu_opnd0[31] == alu_opnd1[31]) && (m_r[31] != alu_opnd0[31]);
        end else if (alu_cntl[ALU_SUB]) begin
            m_r  = {1'b0, alu_opnd0} - {1'b0, alu_opnd1} - {32'b0, m_cin};
            m_of = (alu_opnd0[31] != alu_opnd1[31]) && (m_r[31] != alu_opnd0[31]);
        end else if (alu_cntl[ALU_AND]) begin
            m_r = {1'b0, alu_opnd0 & alu_opnd1};
        end else if (alu_cntl[ALU_OR]) begin
            m_r = {1'b0, alu_opnd0 | alu_opnd1};
        end else if (alu_cntl[ALU_XOR]) begin
            m_r = {1'b0, alu_opnd0 ^ alu_opnd1};
        end
        alu_result     = m_r;
        alu_status_out = {m_r[32], ~^m_r[7:0], (m_r[31:0] == 32'd0), m_r[31], m_of};
    end

    typedef struct {
        logic [11:0] cntl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        wr;
        logic        fault;
        int          lat;
        logic [4:0]  flg;
    } vec_t;

    localparam logic [11:0] C_ADD = 12'h001;
    localparam logic [11:0] C_SUB = 12'h002;
    localparam logic [11:0] C_XOR = 12'h010;
    localparam logic [11:0] C_DIV = 12'h080;
    localparam logic [11:0] C_ADC = 12'h101;
    localparam logic [11:0] C_SBB = 12'h102;
    localparam logic [11:0] C_CMP = 12'h202;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one op, measure cycles from acceptance to rsp_valid, check
    // the response, then check flags after the handshake (rsp_ready=1).
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit seen;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_cntl  = v.cntl;
        req_opnd0 = v.a;
        req_opnd1 = v.b;
        @(negedge clk);
        req_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 60) begin
            if (rsp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk($sformatf("v%0d latency", idx), seen ? 32'(lat) : 32'd999, 32'(v.lat));
        if (seen) begin
            chk($sformatf("v%0d result", idx), rsp_result, v.res);
            chk($sformatf("v%0d wr", idx), {31'b0, rsp_wr}, {31'b0, v.wr});
            chk($sformatf("v%0d fault", idx), {31'b0, rsp_fault}, {31'b0, v.fault});
            @(negedge clk);
            chk($sformatf("v%0d flags", idx), {27'b0, flags}, {27'b0, v.flg});
            chk($sformatf("v%0d rsp_valid drop", idx), {31'b0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        int n;
        // cntl, a, b, result, wr, fault, latency, flags {CF,PF,ZF,SF,OF}
        vecs[0]  = '{C_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0,  2, 5'b11100};
        vecs[1]  = '{C_CMP, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0,  2, 5'b10010};
        vecs[2]  = '{C_DIV, 32'd100,      32'd7,        32'h0000000E, 1'b1, 1'b0, 34, 5'b10010};
        vecs[3]  = '{C_DIV, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 1'b1, 1'b0, 34, 5'b10010};
        vecs[4]  = '{C_DIV, 32'd1234,     32'd0,        32'hFFFFFFFF, 1'b0, 1'b1,  1, 5'b10010};
        vecs[5]  = '{C_ADC, 32'h00000001, 32'h00000001, 32'h00000003, 1'b1, 1'b0,  2, 5'b01000};
        vecs[6]  = '{C_XOR, 32'h80000000, 32'h00000001, 32'h80000001, 1'b1, 1'b0,  2, 5'b00010};
        vecs[7]  = '{C_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0,  2, 5'b01011};
        vecs[8]  = '{C_DIV, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 34, 5'b01011};
        vecs[9]  = '{C_DIV, 32'd7,        32'd100,      32'h00000000, 1'b1, 1'b0, 34, 5'b01011};
        vecs[10] = '{C_CMP, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0,  2, 5'b11010};
        vecs[11] = '{C_SBB, 32'd10,       32'd3,        32'h00000006, 1'b1, 1'b0,  2, 5'b01000};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_cntl  = '0;
        req_opnd0 = '0;
        req_opnd1 = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst rsp_result", rsp_result, 32'd0);
        chk("rst rsp_wr_fault", {30'b0, rsp_wr, rsp_fault}, 32'd0);
        chk("rst alu_cntl", {20'b0, alu_cntl}, 32'd0);
        chk("rst alu_opnds", alu_opnd0 | alu_opnd1, 32'd0);
        chk("rst flags", {27'b0, flags}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle req_ready", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Stalled response: rsp_* stable and flags held until handshake
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_cntl  = C_ADD;
        req_opnd0 = 32'h80000000;
        req_opnd1 = 32'h80000001;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall rsp_valid seen", {31'b0, rsp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d rsp", k),
                {rsp_valid, rsp_wr, rsp_fault, 29'b0} ^ rsp_result, {3'b110, 29'b0} ^ 32'h00000001);
            chk($sformatf("stall%0d flags", k), {27'b0, flags}, {27'b0, 5'b01000});
            chk($sformatf("stall%0d req_ready", k), {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall flags commit", {27'b0, flags}, {27'b0, 5'b10001});
        chk("stall rsp_valid drop", {31'b0, rsp_valid}, 32'd0);

        // Reset asserted in the middle of a divide
        @(negedge clk);
        req_valid = 1'b1;
        req_cntl  = C_DIV;
        req_opnd0 = 32'd100;
        req_opnd1 = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("div alu_cntl", {20'b0, alu_cntl}, {20'b0, ALU_OP_SUB});
        chk("div alu_opnd1", alu_opnd1, 32'd7);
        chk("div rsp_valid low", {31'b0, rsp_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst flags", {27'b0, flags}, 32'd0);
        chk("midrst req_ready", {31'b0, req_ready}, 32'd0);
        chk("midrst alu_cntl", {20'b0, alu_cntl}, 32'd0);
        chk("midrst alu_opnds", alu_opnd0 | alu_opnd1, 32'd0);
        chk("midrst rsp_result", rsp_result, 32'd0);
        chk("midrst rsp_flags", {29'b0, rsp_valid, rsp_wr, rsp_fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("postrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("postrst req_ready", {31'b0, req_ready}, 32'd1);
        chk("postrst flags", {27'b0, flags}, 32'd0);

        // Normal operation resumes after reset
        run_vec(99, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
